spi_share_arb: RTL and testbench
================================

// Module: spi_share_arb
// PURPOSE
//  Shares one SPI_mnrch master between two requesters: port 0 (A2D_intf) and port 1 (inertial sensor intf).
//  Round-robin arbitration, one full 16-bit transaction per grant.
//  Enforces a minimum idle gap between transactions and aborts hung transactions with a timeout.
//  Sits between the requester FSMs and the single SPI_mnrch instance (drives its snd/cmd, consumes done/resp).
// PARAMETERS
//  GAP_CYC  4   clk cycles spent in GAP after each completion before the next grant (>=1)
//  TMO_W    16  timeout counter width; a transaction aborts after 2**TMO_W-1 BUSY cycles without spi_done
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst_n     in   1   asynchronous active-low reset
//  req0      in   1   requester 0 level request; held with cmd0 stable until rdy0
//  cmd0      in   16  requester 0 SPI command word
//  rdy0      out  1   1-cycle pulse: requester 0 transaction finished, resp0 valid
//  resp0     out  16  requester 0 response word, held until its next completion
//  req1/cmd1/rdy1/resp1 -- same as above for requester 1
//  gnt       out  2   one-hot current owner (2'b00 when IDLE/GAP)
//  spi_snd   out  1   1-cycle start pulse to SPI_mnrch
//  spi_cmd   out  16  registered command to SPI_mnrch, stable for whole transaction
//  spi_done  in   1   SPI_mnrch completion pulse
//  spi_resp  in   16  SPI_mnrch response, valid with spi_done
//  tmo_err   out  1   1-cycle pulse on transaction timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (port 0 has priority first)
//  Reset: gnt=0, spi_snd=0, spi_cmd=0, rdy0/1=0, resp0/1=0, tmo_err=0, gap/timeout counters=0
//  All outputs are registered.
//  FSM states: IDLE, BUSY, GAP.
//  IDLE: req0/req1 sampled only here.
//   - One request pending: grant that port.
//   - Both pending: grant rr_ptr port.
//   - On grant, next cycle: BUSY, gnt one-hot, spi_cmd<=cmdN, spi_snd=1 for exactly that cycle.
//   - Latency: req sampled at edge t -> spi_snd high in cycle t+1.
//  BUSY: spi_snd=0; timeout counter increments each cycle.
//   - spi_done=1: respN<=spi_resp, rdyN=1 next cycle, rr_ptr<=~owner, gnt<=0, -> GAP.
//   - Counter reaches 2**TMO_W-1 without done: respN<=16'hFFFF, rdyN=1, tmo_err=1, rr_ptr<=~owner, -> GAP.
//   - Done arriving on the same cycle as the counter reaches max: done wins, no tmo_err.
//  GAP: counts GAP_CYC cycles, then -> IDLE; counters clear on exit.
//   - GAP gives the requester time to drop req after rdy.
//   - A req still high on return to IDLE is a new request.
//  rr_ptr toggles only on completion or timeout, so the last owner loses ties.
//  spi_done seen in IDLE or GAP is ignored: no rdy, no resp update.
//  Request changes while BUSY are ignored; spi_cmd is not re-sampled.
//  rdy0 and rdy1 are never high together; gnt is never 2'b11.
//  Reset mid-transaction: immediate return to reset values; no rdy is produced for the aborted transfer.
// TESTING
//  1. Single req0, cmd0=16'h0800, spi_done after 40 cyc with spi_resp=16'h0ABC
//     -> spi_snd 1 cyc after req, spi_cmd=16'h0800, gnt=01, rdy0 pulse, resp0=16'h0ABC, rdy1 never.
//  2. req0 and req1 high together from reset
//     -> grants alternate 0,1,0,1; spacing between spi_snd pulses >= done latency + GAP_CYC + 1.
//  3. Only req1 high continuously -> back-to-back grants to port 1 each separated by 4 GAP cycles.
//  4. TMO_W=6, spi_done never asserted -> after 63 BUSY cyc: tmo_err pulse, rdy owner pulse, resp=16'hFFFF, FSM returns IDLE.
//  5. spi_done pulsed in IDLE with spi_resp=16'h1234 -> no rdy, resp0/1 unchanged.
//  6. rst_n low 3 cyc mid-BUSY -> all outputs 0 asynchronously.
//     After release, the pending req0 is regranted with a fresh spi_snd.

Source files
------------

// File: rtl/spi_share_arb.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// One 16-bit transaction per grant, followed by a fixed idle gap; hung transfers time out.
module spi_share_arb #(
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned TMO_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  output logic        rdy0,
  output logic [15:0] resp0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        rdy1,
  output logic [15:0] resp1,
  output logic [1:0]  gnt,
  output logic        spi_snd,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_resp,
  output logic        tmo_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  localparam int unsigned   GapW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] TmoMax  = '1;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              spi_snd_q, spi_snd_d;
  logic [15:0]       spi_cmd_q, spi_cmd_d;
  logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic [15:0]       resp0_q, resp0_d, resp1_q, resp1_d;
  logic              tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              sel;
  logic [15:0]       fin_resp;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    spi_snd_d = 1'b0;
    spi_cmd_d = spi_cmd_q;
    rdy0_d    = 1'b0;
    rdy1_d    = 1'b0;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
    tmo_err_d = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sel       = 1'b0;
    tmo_inc   = tmo_cnt_q + 1'b1;
    fin_resp  = spi_done ? spi_resp : 16'hFFFF;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the round-robin pointer picks; otherwise the lone requester wins.
          sel       = (req0 && req1) ? rr_ptr_q : req1;
          gnt_d     = sel ? 2'b10 : 2'b01;
          spi_cmd_d = sel ? cmd1 : cmd0;
          spi_snd_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        tmo_cnt_d = tmo_inc;
        // Done takes precedence over a timeout landing on the same cycle.
        if (spi_done || (tmo_inc == TmoMax)) begin
          if (gnt_q[1]) begin
            rdy1_d  = 1'b1;
            resp1_d = fin_resp;
          end else begin
            rdy0_d  = 1'b1;
            resp0_d = fin_resp;
          end
          tmo_err_d = ~spi_done;
          rr_ptr_d  = ~gnt_q[1];
          gnt_d     = 2'b00;
          gap_cnt_d = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 1'b0;
      gnt_q     <= 2'b00;
      spi_snd_q <= 1'b0;
      spi_cmd_q <= 16'h0000;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      resp0_q   <= 16'h0000;
      resp1_q   <= 16'h0000;
      tmo_err_q <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      spi_snd_q <= spi_snd_d;
      spi_cmd_q <= spi_cmd_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
      tmo_err_q <= tmo_err_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign spi_snd = spi_snd_q;
  assign spi_cmd = spi_cmd_q;
  assign rdy0    = rdy0_q;
  assign rdy1    = rdy1_q;
  assign resp0   = resp0_q;
  assign resp1   = resp1_q;
  assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_spi_share_arb.sv
// Scoreboard bench for spi_share_arb: stimulus queues expected grants/completions,
// a negedge monitor pops and compares whenever spi_snd or a rdy/tmo_err pulse appears.
module tb_spi_share_arb;

  localparam int GAP_CYC = 4;
  localparam int TMO_W   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] cmd0 = '0, cmd1 = '0;
  logic        rdy0, rdy1;
  logic [15:0] resp0, resp1;
  logic [1:0]  gnt;
  logic        spi_snd;
  logic [15:0] spi_cmd;
  logic        spi_done = 1'b0;
  logic [15:0] spi_resp = '0;
  logic        tmo_err;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        port;
    logic [15:0] val;
    logic        tmo;
  } exp_t;

  exp_t gq[$];
  exp_t cq[$];

  spi_share_arb #(.GAP_CYC(GAP_CYC), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .rdy0(rdy0), .resp0(resp0),
    .req1(req1), .cmd1(cmd1), .rdy1(rdy1), .resp1(resp1),
    .gnt(gnt), .spi_snd(spi_snd), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_resp(spi_resp), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_eq(input string name, input logic [63:0] act,
                                   input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic port, input logic [15:0] val, input logic tmo);
    exp_t e;
    e.port = port;
    e.val  = val;
    e.tmo  = tmo;
    return e;
  endfunction

  task automatic wait_snd(output int s);
    int n;
    n = 0;
    @(negedge clk);
    while (!spi_snd && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("snd_seen", spi_snd, 1);
    s = cyc;
  endtask

  task automatic pulse_done(input int lat, input logic [15:0] r);
    repeat (lat) @(posedge clk);
    #1 spi_done = 1'b1;
    spi_resp = r;
    @(posedge clk);
    #1 spi_done = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every spi_snd must match a queued grant, every rdy/tmo a queued completion.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (spi_snd) begin
          check_eq("grant_expected", gq.size() != 0, 1);
          if (gq.size() != 0) begin
            e = gq.pop_front();
            check_eq("gnt", gnt, e.port ? 2'b10 : 2'b01);
            check_eq("spi_cmd", spi_cmd, e.val);
          end
        end
        if (rdy0 || rdy1 || tmo_err) begin
          check_eq("rdy_expected", cq.size() != 0, 1);
          if (cq.size() != 0) begin
            e = cq.pop_front();
            check_eq("rdy0", rdy0, !e.port);
            check_eq("rdy1", rdy1, e.port);
            check_eq("resp", e.port ? resp1 : resp0, e.val);
            check_eq("tmo_err", tmo_err, e.tmo);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int s, prev, n;
    logic [15:0] r2 [4];
    r2[0] = 16'h2001; r2[1] = 16'h2002; r2[2] = 16'h2003; r2[3] = 16'h2004;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {gnt, spi_snd, spi_cmd, rdy0, rdy1, resp0, resp1, tmo_err}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: single req0, done after 40 cycles
    gq.push_back(mk(1'b0, 16'h0800, 1'b0));
    cq.push_back(mk(1'b0, 16'h0ABC, 1'b0));
    @(posedge clk);
    #1 req0 = 1'b1;
    cmd0 = 16'h0800;
    @(negedge clk);
    check_eq("t1_snd_early", spi_snd, 0);
    @(negedge clk);
    check_eq("t1_snd_latency", spi_snd, 1);
    @(negedge clk);
    check_eq("t1_snd_one_cycle", spi_snd, 0);
    pulse_done(40, 16'h0ABC);
    req0 = 1'b0;
    @(negedge clk);
    check_eq("t1_rdy0", rdy0, 1);
    check_eq("t1_resp0", resp0, 16'h0ABC);
    repeat (8) @(posedge clk);

    // 2: both requesting from reset alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      gq.push_back(mk(i[0], i[0] ? 16'hB111 : 16'hA000, 1'b0));
      cq.push_back(mk(i[0], r2[i], 1'b0));
    end
    @(posedge clk);
    #1 req0 = 1'b1;
    req1 = 1'b1;
    cmd0 = 16'hA000;
    cmd1 = 16'hB111;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_snd(s);
      // done latency + gap cycles + one rdy-to-idle cycle + one idle sampling cycle
      if (i > 0) check_eq("t2_snd_spacing", 64'(s - prev), 64'(10 + GAP_CYC + 2));
      prev = s;
      pulse_done(10, r2[i]);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (8) @(posedge clk);

    // 3: req1 alone, held high
    for (int i = 0; i < 3; i++) begin
      gq.push_back(mk(1'b1, 16'hC0DE, 1'b0));
      cq.push_back(mk(1'b1, 16'h3001 + 16'(i), 1'b0));
    end
    @(posedge clk);
    #1 req1 = 1'b1;
    cmd1 = 16'hC0DE;
    for (int i = 0; i < 3; i++) begin
      wait_snd(s);
      if (i > 0) check_eq("t3_snd_spacing", 64'(s - prev), 64'(5 + GAP_CYC + 2));
      prev = s;
      pulse_done(5, 16'h3001 + 16'(i));
    end
    req1 = 1'b0;
    repeat (8) @(posedge clk);

    // 4: timeout after 2**TMO_W-1 busy cycles
    gq.push_back(mk(1'b0, 16'h4444, 1'b0));
    cq.push_back(mk(1'b0, 16'hFFFF, 1'b1));
    @(posedge clk);
    #1 req0 = 1'b1;
    cmd0 = 16'h4444;
    wait_snd(s);
    n = 0;
    @(negedge clk);
    while (!tmo_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_tmo_seen", tmo_err, 1);
    check_eq("t4_tmo_cycles", 64'(cyc - s), 64'((1 << TMO_W) - 1));
    check_eq("t4_gnt_cleared", gnt, 2'b00);
    @(negedge clk);
    check_eq("t4_tmo_one_cycle", tmo_err, 0);
    @(posedge clk);
    #1 req0 = 1'b0;
    repeat (10) @(posedge clk);

    // 5: stray done while idle is ignored
    #1 spi_done = 1'b1;
    spi_resp = 16'h1234;
    @(posedge clk);
    #1 spi_done = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5_resp0_held", resp0, 16'hFFFF);
    check_eq("t5_resp1_held", resp1, 16'h3003);
    check_eq("t5_gnt_idle", gnt, 2'b00);

    // 6: reset mid-busy, then regrant of the still-pending req0
    gq.push_back(mk(1'b0, 16'h5A5A, 1'b0));
    @(posedge clk);
    #1 req0 = 1'b1;
    cmd0 = 16'h5A5A;
    wait_snd(s);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("t6_async_reset", {gnt, spi_snd, spi_cmd, rdy0, rdy1, resp0, resp1, tmo_err},
                64'h0);
    gq.push_back(mk(1'b0, 16'h5A5A, 1'b0));
    cq.push_back(mk(1'b0, 16'h6789, 1'b0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_snd(s);
    pulse_done(7, 16'h6789);
    req0 = 1'b0;
    repeat (10) @(posedge clk);

    check_eq("grants_drained", gq.size(), 0);
    check_eq("completions_drained", cq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
